interleave_settle_monitor: RTL and testbench

- Clocked, parametrised successor to the scalar interleave experiments.
- Drives a WIDTH-bit stimulus onto CHANNELS propagation paths built in the enclosing test module (assign, always_comb, gate, or registered paths).
- Counts the cycles each path takes to settle to its expected value and reports pass/fail per channel.
- Sits beside the paths under test as a self-checking harness.

---
 rtl/interleave_settle_monitor.sv | 168 ++++++++++++++++
 tb/tb_interleave_settle_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/interleave_settle_monitor.sv
// interleave_settle_monitor
// Drives a registered stimulus into CHANNELS propagation paths built around
// this block. It then counts how many cycles each path takes to settle to its
// expected value and reports the result for each channel.
//
// Optional build macro: INTERLEAVE_SETTLE_XZ_CHECK_EN
//   When defined, matching uses case equality and channels holding X/Z bits
//   are reported in xz_mask. When undefined, xz_mask is tied to 0.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a run (accepted only in IDLE)
//   stim          stimulus value, sampled when start is accepted
//   mode          per-channel expectation: 0 = copy, 1 = increment
//   chan_val      observed path outputs, channel k at [k*WIDTH +: WIDTH]
//   drv           registered stimulus driven into all paths
//   busy          high while a run is in SETTLE or REPORT
//   done          one-cycle pulse while in REPORT
//   pass          every channel matched in the last run
//   mismatch_mask bit k set if channel k never matched
//   xz_mask       bit k set if channel k held X/Z at the end of the run
//   settle_max    largest first-match cycle index across matched channels
module interleave_settle_monitor #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [WIDTH-1:0]                     stim,
  input  logic [CHANNELS-1:0]                  mode,
  input  logic [CHANNELS*WIDTH-1:0]            chan_val,
  output logic [WIDTH-1:0]                     drv,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic [CHANNELS-1:0]                  mismatch_mask,
  output logic [CHANNELS-1:0]                  xz_mask,
  output logic [$clog2(SETTLE_CYCLES+1)-1:0]   settle_max
);

  localparam int unsigned SMW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SMW-1:0] LAST_CNT = SMW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_REPORT} state_t;

  state_t              state, state_d;
  logic [SMW-1:0]      cnt, cnt_d;
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] matched, matched_d;
  logic [WIDTH-1:0]    drv_d;
  logic                busy_d, done_d, pass_d;
  logic [CHANNELS-1:0] mismatch_d, xz_d;
  logic [SMW-1:0]      settle_max_d;

  logic [CHANNELS-1:0] hit;     // unmatched channel matching this cycle
  logic [CHANNELS-1:0] xz_now;  // channel currently carries X/Z bits

  // Per-channel expected value and first-match detection; drv doubles as
  // the captured stimulus since it only changes on an accepted start.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [WIDTH-1:0] chan_k;
    logic [WIDTH-1:0] exp_k;
    logic             hit_k;

    assign chan_k = chan_val[k*WIDTH +: WIDTH];
    assign exp_k  = mode_q[k] ? WIDTH'(drv + WIDTH'(1)) : drv;

    always_comb begin
      hit_k = 1'b0;
`ifdef INTERLEAVE_SETTLE_XZ_CHECK_EN
      if (!matched[k] && (chan_k === exp_k)) hit_k = 1'b1;
`else
      // An X/Z-resolved compare takes the false branch, so it is no match.
      if (!matched[k] && (chan_k == exp_k)) hit_k = 1'b1;
`endif
    end

    assign hit[k] = hit_k;
`ifdef INTERLEAVE_SETTLE_XZ_CHECK_EN
    assign xz_now[k] = $isunknown(chan_k);
`else
    assign xz_now[k] = 1'b0;
`endif
  end

  // Next-state and next-register values
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    mode_d       = mode_q;
    matched_d    = matched;
    drv_d        = drv;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    mismatch_d   = mismatch_mask;
    xz_d         = xz_mask;
    settle_max_d = settle_max;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SETTLE;
          drv_d        = stim;
          mode_d       = mode;
          matched_d    = '0;
          settle_max_d = '0;
          cnt_d        = '0;
          pass_d       = 1'b0;
          mismatch_d   = '0;
          xz_d         = '0;
          busy_d       = 1'b1;
        end
      end
      S_SETTLE: begin
        matched_d = matched | hit;
        if ((|hit) && (cnt > settle_max)) settle_max_d = cnt;
        if ((&(matched | hit)) || (cnt == LAST_CNT)) begin
          state_d = S_REPORT;
          done_d  = 1'b1;
        end else begin
          cnt_d = SMW'(cnt + SMW'(1));
        end
      end
      S_REPORT: begin
        pass_d     = (&matched) && !(|xz_now);
        mismatch_d = ~matched;
        xz_d       = xz_now;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      mode_q        <= '0;
      matched       <= '0;
      drv           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_mask <= '0;
      xz_mask       <= '0;
      settle_max    <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      mode_q        <= mode_d;
      matched       <= matched_d;
      drv           <= drv_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      mismatch_mask <= mismatch_d;
      xz_mask       <= xz_d;
      settle_max    <= settle_max_d;
    end
  end

endmodule

// File: tb/tb_interleave_settle_monitor.sv
// Directed bench for interleave_settle_monitor (WIDTH=4, CHANNELS=4,
// SETTLE_CYCLES=8). Paths: ch0=drv, ch1=drv+1, ch2=drv or a 3-stage
// register pipeline, ch3=drv+1 or stuck at 0; ch0 can be overridden.
module tb_interleave_settle_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  stim;
  logic [3:0]  mode;
  logic [15:0] chan_val;
  logic [3:0]  drv;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  mismatch_mask;
  logic [3:0]  xz_mask;
  logic [3:0]  settle_max;

  int total;
  int bad;

  logic       ch2_pipe;
  logic       ch3_stuck;
  logic       ch0_force;
  logic [3:0] ch0_force_val;
  logic [3:0] p1, p2, p3;

  interleave_settle_monitor #(
    .WIDTH(4), .CHANNELS(4), .SETTLE_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .mode(mode),
    .chan_val(chan_val), .drv(drv), .busy(busy), .done(done), .pass(pass),
    .mismatch_mask(mismatch_mask), .xz_mask(xz_mask), .settle_max(settle_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= drv;
    p2 <= p1;
    p3 <= p2;
  end

  always_comb begin
    chan_val[3:0]   = ch0_force ? ch0_force_val : drv;
    chan_val[7:4]   = 4'(drv + 4'd1);
    chan_val[11:8]  = ch2_pipe ? p3 : drv;
    chan_val[15:12] = ch3_stuck ? 4'h0 : 4'(drv + 4'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge (the accepting edge when idle).
  task automatic kick(input logic [3:0] s, input logic [3:0] m);
    start = 1'b1;
    stim  = s;
    mode  = m;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (drv !== 4'h0) begin bad++; $display("FAIL reset_drv got=%h want=0", drv); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
    total++; if ({mismatch_mask, xz_mask} !== 8'h00) begin bad++; $display("FAIL reset_masks got=%h want=00", {mismatch_mask, xz_mask}); end
    total++; if (settle_max !== 4'h0) begin bad++; $display("FAIL reset_settle_max got=%h want=0", settle_max); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_comb(input logic [3:0] s);
    int n;
    kick(s, 4'b1010);
    total++; if (busy !== 1'b1 || drv !== s) begin bad++; $display("FAIL comb_accept busy=%b drv=%h want busy=1 drv=%h", busy, drv, s); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    total++; if (n !== 1) begin bad++; $display("FAIL comb_latency got=%0d want=1", n); end
    total++; if (settle_max !== 4'd0) begin bad++; $display("FAIL comb_settle_max got=%0d want=0", settle_max); end
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL comb_end done=%b busy=%b want 0 0", done, busy); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL comb_pass stim=%h got=%b want=1", s, pass); end
    total++; if (mismatch_mask !== 4'b0000) begin bad++; $display("FAIL comb_mismatch got=%b want=0000", mismatch_mask); end
    step();
  endtask

  task automatic test_pipeline();
    int bc;
    ch2_pipe = 1'b1;
    kick(4'hA, 4'b1010);
    bc = 0;
    while (busy === 1'b1 && bc < 40) begin bc++; step(); end
    total++; if (bc !== 5) begin bad++; $display("FAIL pipe_busy_cycles got=%0d want=5", bc); end
    total++; if (settle_max !== 4'd3) begin bad++; $display("FAIL pipe_settle_max got=%0d want=3", settle_max); end
    total++; if (pass !== 1'b1 || mismatch_mask !== 4'b0000) begin bad++; $display("FAIL pipe_result pass=%b mm=%b want 1 0000", pass, mismatch_mask); end
    ch2_pipe = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    ch3_stuck = 1'b1;
    kick(4'h5, 4'b0010);
    n = 0;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL timeout_latency got=%0d want=8", n); end
    step();
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL timeout_pass got=%b want=0", pass); end
    total++; if (mismatch_mask !== 4'b1000) begin bad++; $display("FAIL timeout_mismatch got=%b want=1000", mismatch_mask); end
    total++; if (settle_max !== 4'd0) begin bad++; $display("FAIL timeout_settle_max got=%0d want=0", settle_max); end
    ch3_stuck = 1'b0;
    step();
  endtask

  task automatic test_ignored_start();
    int n;
    ch2_pipe = 1'b1;
    kick(4'hA, 4'b1010);
    step();
    kick(4'h3, 4'b0000);
    total++; if (drv !== 4'hA || busy !== 1'b1) begin bad++; $display("FAIL ign_drv drv=%h busy=%b want A 1", drv, busy); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL ign_latency got=%0d want=2", n); end
    step();
    total++; if (pass !== 1'b1 || settle_max !== 4'd3) begin bad++; $display("FAIL ign_result pass=%b smax=%0d want 1 3", pass, settle_max); end
    step();
    total++; if (busy !== 1'b0 || drv !== 4'hA) begin bad++; $display("FAIL ign_not_queued busy=%b drv=%h want 0 A", busy, drv); end
    ch2_pipe = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    saw_done = 1'b0;
    kick(4'h7, 4'b1010);
    ch3_stuck = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || drv !== 4'h0) begin bad++; $display("FAIL midrst_clear busy=%b drv=%h want 0 0", busy, drv); end
    repeat (3) begin step(); if (done !== 1'b0) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin step(); if (done !== 1'b0) saw_done = 1'b1; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b want=0", saw_done); end
    ch3_stuck = 1'b0;
  endtask

  task automatic test_xz();
    logic       probe;
    logic       four_state;
    logic [3:0] want_xz;
    int n;
    probe = 1'bx;
    four_state = $isunknown(probe);
    ch0_force = 1'b1;
    ch0_force_val = four_state ? 4'bx101 : 4'b1101;
    want_xz = 4'b0000;
`ifdef INTERLEAVE_SETTLE_XZ_CHECK_EN
    if (four_state) want_xz = 4'b0001;
`endif
    kick(4'h5, 4'b1010);
    n = 0;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL xz_latency got=%0d want=8", n); end
    step();
    total++; if (mismatch_mask !== 4'b0001) begin bad++; $display("FAIL xz_mismatch got=%b want=0001", mismatch_mask); end
    total++; if (xz_mask !== want_xz) begin bad++; $display("FAIL xz_mask got=%b want=%b", xz_mask, want_xz); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL xz_pass got=%b want=0", pass); end
    ch0_force = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stim = 4'h0;
    mode = 4'h0;
    ch2_pipe = 1'b0;
    ch3_stuck = 1'b0;
    ch0_force = 1'b0;
    ch0_force_val = 4'h0;
    test_reset();
    test_comb(4'h5);
    test_comb(4'hF);
    test_pipeline();
    test_timeout();
    test_ignored_start();
    test_reset_mid_run();
    test_xz();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
